// File: rtl/alsu_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alsu_driver : command/response front end that drives an ALSU core's pins  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module alsu_driver #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_opcode,
  input  logic [2:0]       cmd_a,
  input  logic [2:0]       cmd_b,
  input  logic             cmd_cin,
  input  logic             cmd_serial_in,
  input  logic             cmd_red_a,
  input  logic             cmd_red_b,
  input  logic             cmd_bypass_a,
  input  logic             cmd_bypass_b,
  input  logic             cmd_direction,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [2:0]       A,
  output logic [2:0]       B,
  output logic [2:0]       opcode,
  output logic             cin,
  output logic             serial_in,
  output logic             red_op_A,
  output logic             red_op_B,
  output logic             bypass_A,
  output logic             bypass_B,
  output logic             direction,
  input  logic [5:0]       out,
  input  logic [15:0]      leds,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [5:0]       rsp_out,
  output logic [15:0]      rsp_leds,
  output logic             rsp_invalid
);

  localparam int WAIT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LATENCY);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [1:0]        state_q, state_d;
  logic [15:0]       cmd_q, cmd_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [5:0]        rsp_out_q, rsp_out_d;
  logic [15:0]       rsp_leds_q, rsp_leds_d;
  logic              rsp_invalid_q, rsp_invalid_d;

  // Latched command layout matches the pin concatenation in the output process
  logic [2:0] lat_op;
  logic       lat_red_a;
  logic       lat_red_b;
  logic       lat_invalid;

  assign lat_op      = cmd_q[9:7];
  assign lat_red_a   = cmd_q[4];
  assign lat_red_b   = cmd_q[3];
  assign lat_invalid = (lat_op == 3'd6) || (lat_op == 3'd7) ||
                       ((lat_op > 3'd1) && (lat_red_a || lat_red_b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      issue_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_out_q     <= '0;
      rsp_leds_q    <= '0;
      rsp_invalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      issue_cnt_q   <= issue_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_out_q     <= rsp_out_d;
      rsp_leds_q    <= rsp_leds_d;
      rsp_invalid_q <= rsp_invalid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    issue_cnt_d   = issue_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    rsp_out_d     = rsp_out_q;
    rsp_leds_d    = rsp_leds_q;
    rsp_invalid_d = rsp_invalid_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_d       = {cmd_a, cmd_b, cmd_opcode, cmd_cin, cmd_serial_in,
                         cmd_red_a, cmd_red_b, cmd_bypass_a, cmd_bypass_b,
                         cmd_direction};
          issue_cnt_d = (cmd_count == '0) ? CNT_ONE : cmd_count;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        issue_cnt_d = issue_cnt_q - CNT_ONE;
        if (issue_cnt_q == CNT_ONE) begin
          wait_cnt_d = WAIT_LOAD;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - WAIT_ONE;
        if (wait_cnt_q == WAIT_ONE) begin
          rsp_out_d     = out;
          rsp_leds_d    = leds;
          rsp_invalid_d = lat_invalid;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered so that ready stays low while reset is asserted
    cmd_ready_d = (state_d == IDLE);
  end

  always_comb begin
    {A, B, opcode, cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B,
     direction} = (state_q == ISSUE) ? cmd_q : 16'h0000;
    rsp_valid   = (state_q == RESP);
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_out     = rsp_out_q;
  assign rsp_leds    = rsp_leds_q;
  assign rsp_invalid = rsp_invalid_q;

endmodule
`default_nettype wire

// File: tb/tb_alsu_driver.sv
`default_nettype none
// Bench for alsu_driver: a two-stage ALSU model answers the driven pins and
// every response is compared against a command-level reference.
module tb_alsu_driver;

  localparam int LATENCY = 2;
  localparam int CNT_W   = 4;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic       cin, si, ra, rb, ba, bb, dir;
    logic [3:0] count;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n, alsu_rst, full_adder;
  logic cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_invalid;
  logic [2:0] cmd_opcode, cmd_a, cmd_b, A, B, opcode;
  logic cmd_cin, cmd_serial_in, cmd_red_a, cmd_red_b, cmd_bypass_a, cmd_bypass_b, cmd_direction;
  logic [CNT_W-1:0] cmd_count;
  logic cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
  logic [5:0] out, rsp_out;
  logic [15:0] leds, rsp_leds;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alsu_driver #(.LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
    .cmd_serial_in(cmd_serial_in), .cmd_red_a(cmd_red_a), .cmd_red_b(cmd_red_b),
    .cmd_bypass_a(cmd_bypass_a), .cmd_bypass_b(cmd_bypass_b),
    .cmd_direction(cmd_direction), .cmd_count(cmd_count),
    .A(A), .B(B), .opcode(opcode), .cin(cin), .serial_in(serial_in),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A),
    .bypass_B(bypass_B), .direction(direction), .out(out), .leds(leds),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
    .rsp_leds(rsp_leds), .rsp_invalid(rsp_invalid)
  );

  // ALSU model: inputs registered on one edge, result registered on the next
  logic [2:0] a_r, b_r, op_r;
  logic cin_r, si_r, ra_r, rb_r, ba_r, bb_r, dir_r, inv_r;
  assign inv_r = (op_r >= 3'd6) || (op_r > 3'd1 && (ra_r || rb_r));

  always @(posedge clk or posedge alsu_rst) begin
    if (alsu_rst) begin
      {a_r, b_r, op_r, cin_r, si_r, ra_r, rb_r, ba_r, bb_r, dir_r} <= '0;
      out  <= '0;
      leds <= '0;
    end else begin
      {a_r, b_r, op_r, cin_r, si_r, ra_r, rb_r, ba_r, bb_r, dir_r} <=
        {A, B, opcode, cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction};
      if (inv_r) begin
        out  <= '0;
        leds <= ~leds;
      end else begin
        leds <= '0;
        if (ba_r)      out <= {3'b000, a_r};
        else if (bb_r) out <= {3'b000, b_r};
        else begin
          case (op_r)
            3'd0: out <= ra_r ? {5'b0, |a_r} : rb_r ? {5'b0, |b_r} : {3'b000, a_r | b_r};
            3'd1: out <= ra_r ? {5'b0, ^a_r} : rb_r ? {5'b0, ^b_r} : {3'b000, a_r ^ b_r};
            3'd2: out <= {3'b000, a_r} + {3'b000, b_r} + {5'b0, cin_r & full_adder};
            3'd3: out <= {3'b000, a_r} * {3'b000, b_r};
            3'd4: out <= dir_r ? {out[4:0], si_r} : {si_r, out[5:1]};
            default: out <= dir_r ? {out[4:0], out[5]} : {out[0], out[5:1]};
          endcase
        end
      end
    end
  end

  // Reference: what the response should hold, from the command alone
  function automatic void ref_rsp(input cmd_t c, output logic [5:0] o,
                                  output logic [15:0] l, output logic inv);
    int n, v;
    n   = (c.count == 0) ? 1 : int'(c.count);
    inv = (c.op >= 6) || (c.op > 1 && (c.ra || c.rb));
    v   = 0;
    l   = 16'h0000;
    if (inv) begin
      l = (n % 2 == 1) ? 16'hFFFF : 16'h0000;
    end else if (c.ba) v = int'(c.a);
    else if (c.bb) v = int'(c.b);
    else begin
      case (c.op)
        3'd0: v = c.ra ? int'(c.a != 0) : c.rb ? int'(c.b != 0) : int'(c.a | c.b);
        3'd1: v = c.ra ? $countones(c.a) % 2 : c.rb ? $countones(c.b) % 2 : int'(c.a ^ c.b);
        3'd2: v = int'(c.a) + int'(c.b) + (full_adder ? int'(c.cin) : 0);
        3'd3: v = int'(c.a) * int'(c.b);
        3'd4: repeat (n) v = c.dir ? (((v << 1) | int'(c.si)) & 63) : ((v >> 1) | (int'(c.si) << 5));
        default: repeat (n) v = c.dir ? (((v << 1) | (v >> 5)) & 63) : ((v >> 1) | ((v & 1) << 5));
      endcase
    end
    o = 6'(v);
  endfunction

  function automatic cmd_t mk(input int op, a, b, cin_v, si, ra, rb, ba, bb, dir, cnt);
    cmd_t c;
    c = '{op: 3'(op), a: 3'(a), b: 3'(b), cin: 1'(cin_v), si: 1'(si), ra: 1'(ra),
          rb: 1'(rb), ba: 1'(ba), bb: 1'(bb), dir: 1'(dir), count: 4'(cnt)};
    return c;
  endfunction

  function automatic logic [15:0] pins();
    return {A, B, opcode, cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input cmd_t c);
    {cmd_opcode, cmd_a, cmd_b} = {c.op, c.a, c.b};
    {cmd_cin, cmd_serial_in, cmd_red_a, cmd_red_b} = {c.cin, c.si, c.ra, c.rb};
    {cmd_bypass_a, cmd_bypass_b, cmd_direction, cmd_count} = {c.ba, c.bb, c.dir, c.count};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pins"}, 32'(pins()), 32'h0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_rsp_out"}, 32'(rsp_out), 32'h0);
    check({tag, "_rsp_leds"}, 32'(rsp_leds), 32'h0);
    check({tag, "_rsp_invalid"}, 32'(rsp_invalid), 32'h0);
  endtask

  // Accept one command, follow it to RESP, optionally stall, then hand shake
  task automatic run_cmd(input cmd_t c, input int hold);
    logic [5:0] eo;
    logic [15:0] el;
    logic ei;
    int n, j;
    ref_rsp(c, eo, el, ei);
    n = (c.count == 0) ? 1 : int'(c.count);
    check("accept_ready", 32'(cmd_ready), 32'h1);
    drive(c);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    drive(cmd_t'($urandom));
    check("ready_low_after_accept", 32'(cmd_ready), 32'h0);
    j = 0;
    while (rsp_valid !== 1'b1 && j < 64) begin
      check("issue_pins", 32'(pins()), (j < n) ? 32'({c.a, c.b, c.op, c.cin, c.si, c.ra, c.rb, c.ba, c.bb, c.dir}) : 32'h0);
      step();
      j++;
    end
    check("latency", 32'(j), 32'(n + LATENCY));
    check("resp_pins_zero", 32'(pins()), 32'h0);
    check("rsp_out", 32'(rsp_out), 32'(eo));
    check("rsp_leds", 32'(rsp_leds), 32'(el));
    check("rsp_invalid", 32'(rsp_invalid), 32'(ei));
    cmd_valid = (hold > 0);
    for (int h = 0; h < hold; h++) begin
      step();
      check("stall_valid", 32'(rsp_valid), 32'h1);
      check("stall_ready_low", 32'(cmd_ready), 32'h0);
      check("stall_out", 32'({rsp_out, rsp_leds, rsp_invalid}), 32'({eo, el, ei}));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("post_hs_valid", 32'(rsp_valid), 32'h0);
    check("post_hs_ready", 32'(cmd_ready), 32'h1);
    check("post_hs_keep", 32'({rsp_out, rsp_leds, rsp_invalid}), 32'({eo, el, ei}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    rst_n = 1'b0; alsu_rst = 1'b1; full_adder = 1'b1;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    drive('0);
    #2;
    check_all_zero("reset");
    step();
    check("reset_held_ready", 32'(cmd_ready), 32'h0);
    alsu_rst = 1'b0;
    step();
    rst_n = 1'b1;
    check("ready_before_edge", 32'(cmd_ready), 32'h0);
    step();
    check("ready_first_edge", 32'(cmd_ready), 32'h1);

    run_cmd(mk(2, 3, 2, 1, 0, 0, 0, 0, 0, 0, 1), 0);      // ADD 3+2+1
    run_cmd(mk(3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 1), 0);      // MULT 3*3
    run_cmd(mk(6, 5, 2, 1, 1, 0, 0, 1, 0, 1, 1), 0);      // invalid opcode
    run_cmd(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 0);      // OR 0|0
    run_cmd(mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 1, 3), 4);      // SHIFT x3 with stall
    run_cmd(mk(2, 7, 7, 1, 0, 0, 0, 0, 0, 0, 0), 1);      // count 0 acts as 1
    run_cmd(mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 1, 15), 0);     // max count
    run_cmd(mk(7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2), 0);      // invalid, even count

    // Abort a command during WAIT with an asynchronous reset
    check("abort_accept_ready", 32'(cmd_ready), 32'h1);
    drive(mk(3, 7, 7, 0, 0, 0, 0, 0, 0, 0, 1));
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    step();
    check("abort_held_valid", 32'(rsp_valid), 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("abort_no_rsp", 32'(rsp_valid), 32'h0);
    end
    check("abort_ready", 32'(cmd_ready), 32'h1);
    full_adder = 1'b0;
    run_cmd(mk(2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1), 0);      // ADD 1+1, carry ignored
    full_adder = 1'b1;

    for (int r = 0; r < 40; r++) begin
      c.op = 3'($urandom_range(0, 7));
      c.a = 3'($urandom); c.b = 3'($urandom);
      c.cin = 1'($urandom); c.si = 1'($urandom); c.dir = 1'($urandom);
      c.ra = ($urandom_range(0, 5) == 0); c.rb = ($urandom_range(0, 5) == 0);
      c.ba = ($urandom_range(0, 7) == 0); c.bb = ($urandom_range(0, 7) == 0);
      c.count = 4'($urandom_range(0, 5));
      run_cmd(c, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
